// File: rtl/shift_add_multiplier_datapath_pkg.sv
// Shared definitions for the shift-and-add multiplier datapath.
// Holds the default operand width and the operand/product types at that width.
package shift_add_multiplier_datapath_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef logic [DEFAULT_WIDTH-1:0]   operand_t;
    typedef logic [2*DEFAULT_WIDTH-1:0] product_t;

endpackage

// File: rtl/shift_add_multiplier_datapath_iteration_counter.sv
// Iteration counter for the shift-and-add multiplier.
// It counts the steps while enabled. The done level rises on the step taken at the terminal count and holds until cleared.
module shift_add_multiplier_datapath_iteration_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] i_terminal,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (i_clear) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (i_enable && !r_done) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == i_terminal) begin
                r_done <= 1'b1;
            end
        end
    end

    assign o_cnt  = r_cnt;
    assign o_done = r_done;

endmodule

// File: rtl/shift_add_multiplier_datapath.sv
// Sequential shift-and-add multiplier datapath. It processes one multiplier bit per clock, and a run takes WIDTH clocks.
// Define SIGNED_MULT_EN to treat the operands as two's complement. The default build is unsigned.
module shift_add_multiplier_datapath
    import shift_add_multiplier_datapath_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable_flag,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   product,
    output logic                 counter_flag
);

    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(WIDTH - 1);

    // Handshake with the control unit:
    // - While enable_flag is high, the operands are loaded and all state is cleared. The last high cycle wins.
    // - Each cycle with enable_flag low is one iteration.
    // - counter_flag=1 means product is valid. It holds until enable_flag rises again.
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_product;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_result;
    logic [WIDTH-1:0]   w_load_a;
    logic [WIDTH-1:0]   w_load_b;
    logic [CNT_W-1:0]   w_cnt;
    logic               w_done;
    logic               w_step;
    logic               w_last;

    shift_add_multiplier_datapath_iteration_counter #(
        .CNT_W (CNT_W)
    ) u_iteration_counter (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (enable_flag),
        .i_enable   (!enable_flag),
        .i_terminal (TERMINAL),
        .o_cnt      (w_cnt),
        .o_done     (w_done)
    );

    assign w_step     = !enable_flag && !w_done;
    assign w_last     = w_step && (w_cnt == TERMINAL);
    assign w_acc_next = r_acc + (r_b[0] ? r_a : '0);

`ifdef SIGNED_MULT_EN
    logic r_sign;

    // The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
    assign w_load_a = multiplicand[WIDTH-1] ? -multiplicand : multiplicand;
    assign w_load_b = multiplier[WIDTH-1]   ? -multiplier   : multiplier;
    assign w_result = r_sign ? -w_acc_next : w_acc_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sign <= 1'b0;
        end else if (enable_flag) begin
            r_sign <= multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
        end
    end
`else
    assign w_load_a = multiplicand;
    assign w_load_b = multiplier;
    assign w_result = w_acc_next;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_product <= '0;
        end else if (enable_flag) begin
            r_acc     <= '0;
            r_a       <= {{WIDTH{1'b0}}, w_load_a};
            r_b       <= w_load_b;
            r_product <= '0;
        end else if (w_step) begin
            r_acc <= w_acc_next;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            if (w_last) begin
                r_product <= w_result;
            end
        end
    end

    assign product      = r_product;
    assign counter_flag = w_done;

endmodule
